// File: rtl/id_ex_if.sv
// ID/EX pipeline-register bus: decode-side fields in, execute-side fields out.
// master = decode/control side driving *_in, slave = the ID/EX stage itself.
`timescale 1ns/1ps
interface id_ex_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
);
   // decode side
   logic [1:0]        ctlwb_in;
   logic [2:0]        ctlm_in;
   logic [3:0]        ctlex_in;
   logic [DATA_W-1:0] npc_in;
   logic [DATA_W-1:0] a_in;
   logic [DATA_W-1:0] b_in;
   logic [DATA_W-1:0] signext_in;
   logic [REG_W-1:0]  rs_in;
   logic [REG_W-1:0]  rt_in;
   logic [REG_W-1:0]  rd_in;
   logic              valid_in;
   logic              flush_in;

   // execute side
   logic [1:0]        ctlwb_out;
   logic [2:0]        ctlm_out;
   logic [3:0]        ctlex_out;
   logic [DATA_W-1:0] npc_out;
   logic [DATA_W-1:0] a_out;
   logic [DATA_W-1:0] b_out;
   logic [DATA_W-1:0] signext_out;
   logic [REG_W-1:0]  rs_out;
   logic [REG_W-1:0]  rt_out;
   logic [REG_W-1:0]  rd_out;
   logic              valid_out;
   logic              stall_out;
   logic [CNT_W-1:0]  bubble_cnt_out;

   modport master (
      output ctlwb_in, ctlm_in, ctlex_in, npc_in, a_in, b_in, signext_in,
             rs_in, rt_in, rd_in, valid_in, flush_in,
      input  ctlwb_out, ctlm_out, ctlex_out, npc_out, a_out, b_out, signext_out,
             rs_out, rt_out, rd_out, valid_out, stall_out, bubble_cnt_out
   );

   modport slave (
      input  ctlwb_in, ctlm_in, ctlex_in, npc_in, a_in, b_in, signext_in,
             rs_in, rt_in, rd_in, valid_in, flush_in,
      output ctlwb_out, ctlm_out, ctlex_out, npc_out, a_out, b_out, signext_out,
             rs_out, rt_out, rd_out, valid_out, stall_out, bubble_cnt_out
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS datapath with load-use hazard
// detection. A load in EX whose destination (rt) is read by the decode
// instruction stalls PC and IF/ID for one cycle and turns EX into a bubble.
// A saturating counter records how many bubbles were inserted.
`timescale 1ns/1ps
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input logic   clk,
   input logic   rst_n,
   id_ex_if.slave bus
);

   logic [1:0]        ctlwb_q;
   logic [2:0]        ctlm_q;
   logic [3:0]        ctlex_q;
   logic [DATA_W-1:0] npc_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] signext_q;
   logic [REG_W-1:0]  rs_q;
   logic [REG_W-1:0]  rt_q;
   logic [REG_W-1:0]  rd_q;
   logic              valid_q;
   logic [CNT_W-1:0]  bubble_cnt_q;

   logic              memread_q;
   logic              hazard;
   logic              stall;

   // Load in EX (memread) whose rt feeds the decode instruction; $0 never counts.
   assign memread_q = ctlm_q[1];
   assign hazard    = memread_q & valid_q & (rt_q != '0) & bus.valid_in &
                      ((rt_q == bus.rs_in) | (rt_q == bus.rt_in));
   // A taken-branch flush squashes the decode instruction, so no stall is needed.
   assign stall     = hazard & ~bus.flush_in;

   // Pipeline register update: flush > bubble > normal capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctlwb_q      <= '0;
         ctlm_q       <= '0;
         ctlex_q      <= '0;
         npc_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         signext_q    <= '0;
         rs_q         <= '0;
         rt_q         <= '0;
         rd_q         <= '0;
         valid_q      <= 1'b0;
         bubble_cnt_q <= '0;
      end else if (bus.flush_in) begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         ctlwb_q <= '0;
         ctlm_q  <= '0;
         ctlex_q <= '0;
         valid_q <= 1'b0;
      end else if (stall) begin
         // Bubble: kill controls, hold data fields, count it (saturating).
         ctlwb_q <= '0;
         ctlm_q  <= '0;
         ctlex_q <= '0;
         valid_q <= 1'b0;
         if (bubble_cnt_q != '1) begin
            bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
         end
      end else begin
         ctlwb_q   <= bus.ctlwb_in;
         ctlm_q    <= bus.ctlm_in;
         ctlex_q   <= bus.ctlex_in;
         npc_q     <= bus.npc_in;
         a_q       <= bus.a_in;
         b_q       <= bus.b_in;
         signext_q <= bus.signext_in;
         rs_q      <= bus.rs_in;
         rt_q      <= bus.rt_in;
         rd_q      <= bus.rd_in;
         valid_q   <= bus.valid_in;
      end
   end

   assign bus.ctlwb_out      = ctlwb_q;
   assign bus.ctlm_out       = ctlm_q;
   assign bus.ctlex_out      = ctlex_q;
   assign bus.npc_out        = npc_q;
   assign bus.a_out          = a_q;
   assign bus.b_out          = b_q;
   assign bus.signext_out    = signext_q;
   assign bus.rs_out         = rs_q;
   assign bus.rt_out         = rt_q;
   assign bus.rd_out         = rd_q;
   assign bus.valid_out      = valid_q;
   assign bus.stall_out      = stall;
   assign bus.bubble_cnt_out = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: reset, a hand-derived vector table, directed
// mid-stall reset and back-to-back load sequences, then random stimulus
// against a slot-level reference model. A second instance with a 4-bit
// counter shares the same stimulus so counter saturation is exercised.
`timescale 1ns/1ps
module tb_id_ex_stage;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int CNT_W  = 16;
   localparam int SAT_W  = 4;

   logic clk;
   logic rst_n;

   id_ex_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();
   id_ex_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(SAT_W)) sat_bus ();

   id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(SAT_W)) sat_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sat_bus)
   );

   assign sat_bus.ctlwb_in   = bus.ctlwb_in;
   assign sat_bus.ctlm_in    = bus.ctlm_in;
   assign sat_bus.ctlex_in   = bus.ctlex_in;
   assign sat_bus.npc_in     = bus.npc_in;
   assign sat_bus.a_in       = bus.a_in;
   assign sat_bus.b_in       = bus.b_in;
   assign sat_bus.signext_in = bus.signext_in;
   assign sat_bus.rs_in      = bus.rs_in;
   assign sat_bus.rt_in      = bus.rt_in;
   assign sat_bus.rd_in      = bus.rd_in;
   assign sat_bus.valid_in   = bus.valid_in;
   assign sat_bus.flush_in   = bus.flush_in;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One pipeline slot: what an instruction carries from decode into EX.
   typedef struct packed {
      logic [1:0]  ctlwb;
      logic [2:0]  ctlm;
      logic [3:0]  ctlex;
      logic [31:0] npc;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] se;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic        valid;
   } slot_t;

   typedef struct packed {
      slot_t f;
      logic  flush;
   } in_t;

   typedef struct packed {
      logic [2:0]  ctlm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] a;
      logic        valid;
      logic        flush;
      logic        exp_stall;
      logic        exp_valid;
      logic [2:0]  exp_ctlm;
      logic [4:0]  exp_rt;
      logic [31:0] exp_a;
      logic [15:0] exp_cnt;
   } vec_t;

   int checks   = 0;
   int failures = 0;

   // Reference model: contents of the EX slot and number of bubbles inserted.
   slot_t m;
   int    m_bubbles;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic model_stall(input in_t v);
      logic loaduse;
      loaduse = (m.ctlm[1] == 1'b1) && m.valid && (m.rt != 0) && v.f.valid &&
                (m.rt == v.f.rs || m.rt == v.f.rt);
      return loaduse && !v.flush;
   endfunction

   task automatic model_reset();
      m         = '0;
      m_bubbles = 0;
   endtask

   // Advance the model across one clock edge.
   task automatic model_edge(input in_t v, input logic stalled);
      if (v.flush || stalled) begin
         m.ctlwb = '0;
         m.ctlm  = '0;
         m.ctlex = '0;
         m.valid = 1'b0;
         if (!v.flush) m_bubbles++;
      end else begin
         m = v.f;
      end
   endtask

   task automatic drive(input in_t v);
      bus.ctlwb_in   = v.f.ctlwb;
      bus.ctlm_in    = v.f.ctlm;
      bus.ctlex_in   = v.f.ctlex;
      bus.npc_in     = v.f.npc;
      bus.a_in       = v.f.a;
      bus.b_in       = v.f.b;
      bus.signext_in = v.f.se;
      bus.rs_in      = v.f.rs;
      bus.rt_in      = v.f.rt;
      bus.rd_in      = v.f.rd;
      bus.valid_in   = v.f.valid;
      bus.flush_in   = v.flush;
   endtask

   task automatic check_all(input string tag);
      int full_cnt;
      int sat_cnt;
      full_cnt = (m_bubbles > 65535) ? 65535 : m_bubbles;
      sat_cnt  = (m_bubbles > 15) ? 15 : m_bubbles;
      check({tag, "_ctlwb"},   bus.ctlwb_out,   m.ctlwb);
      check({tag, "_ctlm"},    bus.ctlm_out,    m.ctlm);
      check({tag, "_ctlex"},   bus.ctlex_out,   m.ctlex);
      check({tag, "_npc"},     bus.npc_out,     m.npc);
      check({tag, "_a"},       bus.a_out,       m.a);
      check({tag, "_b"},       bus.b_out,       m.b);
      check({tag, "_se"},      bus.signext_out, m.se);
      check({tag, "_rs"},      bus.rs_out,      m.rs);
      check({tag, "_rt"},      bus.rt_out,      m.rt);
      check({tag, "_rd"},      bus.rd_out,      m.rd);
      check({tag, "_valid"},   bus.valid_out,   m.valid);
      check({tag, "_cnt"},     bus.bubble_cnt_out, full_cnt);
      check({tag, "_sat_cnt"}, sat_bus.bubble_cnt_out, sat_cnt);
   endtask

   // Inputs already driven: check stall, clock once, check registered state.
   task automatic step_rest(input string tag, input in_t v);
      logic s;
      s = model_stall(v);
      check({tag, "_stall"}, bus.stall_out, s);
      check({tag, "_sat_stall"}, sat_bus.stall_out, s);
      @(posedge clk);
      model_edge(v, s);
      #1;
      check_all(tag);
   endtask

   task automatic step(input string tag, input in_t v);
      drive(v);
      #1;
      step_rest(tag, v);
   endtask

   function automatic in_t mk(input logic [2:0] ctlm, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd,
                              input logic [31:0] a, input logic valid,
                              input logic flush);
      in_t v;
      v.f.ctlwb = {valid, ctlm[1]};
      v.f.ctlm  = ctlm;
      v.f.ctlex = ctlm[1] ? 4'b0001 : 4'b1100;
      v.f.npc   = a << 2;
      v.f.a     = a;
      v.f.b     = a ^ 32'h0000_00FF;
      v.f.se    = a + 32'd1000;
      v.f.rs    = rs;
      v.f.rt    = rt;
      v.f.rd    = rd;
      v.f.valid = valid;
      v.flush   = flush;
      return v;
   endfunction

   vec_t        tbl [17];
   in_t         v;
   in_t         prog [4];
   logic [31:0] order [$];
   int          pc;
   logic        s;

   initial begin
      // ctlm  rs  rt  rd   a    vld fl | stall vld ctlm rt a cnt
      tbl[0]  = '{3'b000, 0, 3, 0, 100, 1, 0, 0, 1, 3'b000, 3, 100, 0};
      tbl[1]  = '{3'b010, 1, 5, 0,   1, 1, 0, 0, 1, 3'b010, 5,   1, 0};
      tbl[2]  = '{3'b000, 5, 6, 7,   2, 1, 0, 1, 0, 3'b000, 5,   1, 1};
      tbl[3]  = '{3'b000, 5, 6, 7,   2, 1, 0, 0, 1, 3'b000, 6,   2, 1};
      tbl[4]  = '{3'b010, 2, 0, 0,   4, 1, 0, 0, 1, 3'b010, 0,   4, 1};
      tbl[5]  = '{3'b000, 0, 0, 1,   5, 1, 0, 0, 1, 3'b000, 0,   5, 1};
      tbl[6]  = '{3'b010, 9, 4, 0,   6, 1, 0, 0, 1, 3'b010, 4,   6, 1};
      tbl[7]  = '{3'b000, 6, 7, 1,   7, 1, 0, 0, 1, 3'b000, 7,   7, 1};
      tbl[8]  = '{3'b010, 1, 8, 0,   8, 1, 0, 0, 1, 3'b010, 8,   8, 1};
      tbl[9]  = '{3'b000, 8, 2, 1,   9, 1, 1, 0, 0, 3'b000, 8,   8, 1};
      tbl[10] = '{3'b010, 1, 3, 0,  10, 1, 0, 0, 1, 3'b010, 3,  10, 1};
      tbl[11] = '{3'b000, 1, 3, 0,  11, 0, 0, 0, 0, 3'b000, 3,  11, 1};
      tbl[12] = '{3'b010, 0, 3, 0,  12, 1, 0, 0, 1, 3'b010, 3,  12, 1};
      tbl[13] = '{3'b010, 3, 4, 0,  13, 1, 0, 1, 0, 3'b000, 3,  12, 2};
      tbl[14] = '{3'b010, 3, 4, 0,  13, 1, 0, 0, 1, 3'b010, 4,  13, 2};
      tbl[15] = '{3'b000, 4, 4, 5,  15, 1, 0, 1, 0, 3'b000, 4,  13, 3};
      tbl[16] = '{3'b000, 4, 4, 5,  15, 1, 0, 0, 1, 3'b000, 4,  15, 3};

      // Reset with every input nonzero: outputs clear as soon as rst_n falls.
      rst_n = 1'b1;
      v.f   = '{2'b11, 3'b111, 4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 32'h8765_4321,
                32'hFFFF_FFF0, 5'd31, 5'd31, 5'd31, 1'b1};
      v.flush = 1'b0;
      drive(v);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_all("reset");
      check("reset_stall", bus.stall_out, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Hand-derived vector table.
      for (int i = 0; i < 17; i++) begin
         v = mk(tbl[i].ctlm, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].a,
                tbl[i].valid, tbl[i].flush);
         drive(v);
         #1;
         check($sformatf("tbl%0d_stall", i), bus.stall_out, tbl[i].exp_stall);
         step_rest($sformatf("tbl%0d", i), v);
         check($sformatf("tbl%0d_xvalid", i), bus.valid_out, tbl[i].exp_valid);
         check($sformatf("tbl%0d_xctlm", i), bus.ctlm_out, tbl[i].exp_ctlm);
         check($sformatf("tbl%0d_xrt", i), bus.rt_out, tbl[i].exp_rt);
         check($sformatf("tbl%0d_xa", i), bus.a_out, tbl[i].exp_a);
         check($sformatf("tbl%0d_xcnt", i), bus.bubble_cnt_out, tbl[i].exp_cnt);
      end

      // Reset in the middle of a load-use stall: stall drops immediately.
      step("mr_lw", mk(3'b010, 1, 9, 0, 32'h40, 1, 0));
      v = mk(3'b000, 9, 2, 3, 32'h44, 1, 0);
      drive(v);
      #1;
      check("mr_stall_before", bus.stall_out, 1'b1);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("mr_stall_after", bus.stall_out, 1'b0);
      check_all("mr");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Back-to-back: lw $3 ; lw $4,0($3) ; add $5,$4,$4 with a fetch pointer
      // that holds while stalled.
      prog[0] = mk(3'b010, 0, 3, 0, 1, 1, 0);
      prog[1] = mk(3'b010, 3, 4, 0, 2, 1, 0);
      prog[2] = mk(3'b000, 4, 4, 5, 3, 1, 0);
      prog[3] = mk(3'b000, 0, 0, 0, 0, 0, 0);
      pc = 0;
      order.delete();
      for (int cyc = 0; cyc < 8; cyc++) begin
         v = prog[(pc < 3) ? pc : 3];
         drive(v);
         #1;
         s = bus.stall_out;
         step_rest("b2b", v);
         if (!s && pc < 3) pc++;
         if (bus.valid_out) order.push_back(bus.npc_out);
      end
      check("b2b_done", pc, 3);
      check("b2b_cnt", bus.bubble_cnt_out, 2);
      check("b2b_order_len", order.size(), 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("b2b_order%0d", i),
               (order.size() > i) ? order[i] : 32'hFFFF_FFFF, (i + 1) << 2);
      end

      // Random stimulus with small register numbers so hazards are frequent.
      for (int n = 0; n < 3000; n++) begin
         v.f.ctlwb = 2'($urandom);
         v.f.ctlm  = 3'($urandom);
         v.f.ctlex = 4'($urandom);
         v.f.npc   = $urandom;
         v.f.a     = $urandom;
         v.f.b     = $urandom;
         v.f.se    = $urandom;
         v.f.rs    = 5'($urandom_range(0, 7));
         v.f.rt    = 5'($urandom_range(0, 7));
         v.f.rd    = 5'($urandom_range(0, 31));
         v.f.valid = ($urandom_range(0, 7) != 0);
         v.flush   = ($urandom_range(0, 7) == 0);
         step("rnd", v);
      end
      check("sat_reached", (m_bubbles >= 16) ? sat_bus.bubble_cnt_out : 4'hF, 4'hF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
